// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pkg: RV32I opcode constants, NOP word and encoder result type.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    I_LOAD = 7'b0000011,
    S_TYPE = 7'b0100011,
    B_TYPE = 7'b1100011,
    AUIPC  = 7'b0010111,
    LUI    = 7'b0110111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111
  } opcode_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        imm_err;
  } enc_result_t;

  // True when bits [31:msb] are all copies of the sign bit, i.e. the value
  // is representable as a (msb+1)-bit two's complement number.
  function automatic logic sext_fits(input logic [31:0] value, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb && value[i] != value[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_instr_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_instr_encoder_if: input/output handshake bundle of the encoder.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface riscv_instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, imm_err, out_addr, err_count
  );

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, imm_err, out_addr, err_count
  );

endinterface
`default_nettype wire

// File: rtl/riscv_imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_imm_pack: combinational RV32I field packing and immediate checking.  |
// | Range/alignment checks enabled by RISCV_IMM_RANGE_CHECK_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_imm_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output enc_result_t o_result
);

  logic [31:0] w_instr;
  logic        w_range_ok;
  logic        w_supported;
  logic        w_shift;

  assign w_shift = (i_opcode == I_TYPE) && (i_funct3 == 3'b001 || i_funct3 == 3'b101);

  always_comb begin
    w_instr     = NOP;
    w_range_ok  = 1'b1;
    w_supported = 1'b1;
    case (opcode_e'(i_opcode))
      R_TYPE: w_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      I_TYPE, I_LOAD, JALR: begin
        if (w_shift) begin
          w_instr    = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
          w_range_ok = (i_imm[31:5] == 27'd0);
        end else begin
          w_instr    = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          w_range_ok = sext_fits(i_imm, 11);
        end
      end
      S_TYPE: begin
        w_instr    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_range_ok = sext_fits(i_imm, 11);
      end
      B_TYPE: begin
        w_instr    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], i_opcode};
        w_range_ok = sext_fits(i_imm, 12) && !i_imm[0];
      end
      LUI, AUIPC: begin
        w_instr    = {i_imm[19:0], i_rd, i_opcode};
        w_range_ok = sext_fits(i_imm, 19);
      end
      JAL: begin
        w_instr    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        w_range_ok = sext_fits(i_imm, 20) && !i_imm[0];
      end
      default: w_supported = 1'b0;
    endcase
  end

  assign o_result.instr = w_instr;

`ifdef RISCV_IMM_RANGE_CHECK_EN
  assign o_result.imm_err = !w_supported || !w_range_ok;
`else
  // Checks are computed but discarded; out-of-range fields truncate silently.
  logic unused_chk;
  assign unused_chk       = w_supported ^ w_range_ok;
  assign o_result.imm_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/riscv_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_instr_encoder: registered RV32I encoder with valid/ready handshake,  |
// | output word index and saturating error counter (RISCV_IMM_RANGE_CHECK_EN). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_instr_encoder
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  riscv_instr_encoder_if.slave bus
);

  enc_result_t enc;

  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q,     instr_d;
  logic        imm_err_q,   imm_err_d;
  logic [9:0]  out_addr_q,  out_addr_d;

  logic in_ready;
  logic accept;
  logic out_xfer;

  riscv_imm_pack u_imm_pack (
    .i_opcode (bus.opcode),
    .i_rd     (bus.rd),
    .i_rs1    (bus.rs1),
    .i_rs2    (bus.rs2),
    .i_funct3 (bus.funct3),
    .i_funct7 (bus.funct7),
    .i_imm    (bus.imm),
    .o_result (enc)
  );

  // Single output register: a new word may enter only as the old one leaves.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    imm_err_d   = imm_err_q;
    out_addr_d  = out_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc.instr;
      imm_err_d   = enc.imm_err;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer) out_addr_d = out_addr_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      imm_err_q   <= 1'b0;
      out_addr_q  <= 10'd0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      imm_err_q   <= imm_err_d;
      out_addr_q  <= out_addr_d;
    end
  end

`ifdef RISCV_IMM_RANGE_CHECK_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_xfer && imm_err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= 8'd0;
    else       err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.imm_err   = imm_err_q;
  assign bus.out_addr  = out_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_instr_encoder: scoreboard bench for riscv_instr_encoder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_instr_encoder;

`ifdef RISCV_IMM_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } stim_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  riscv_instr_encoder_if bus ();

  riscv_instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       exp_q[$];
  logic [9:0] exp_addr = 10'd0;
  logic [7:0] exp_err  = 8'd0;

  function automatic stim_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
    stim_t s;
    s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.f3 = f3; s.f7 = f7; s.imm = imm;
    return s;
  endfunction

  // Reference encoder: field layouts from the RV32I formats, ranges checked numerically.
  function automatic exp_t ref_encode(input stim_t s);
    exp_t r;
    int   v;
    logic bad;
    v   = signed'(s.imm);
    bad = 1'b0;
    case (s.op)
      7'b0110011: r.instr = {s.f7, s.rs2, s.rs1, s.f3, s.rd, s.op};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (s.op == 7'b0010011 && (s.f3 == 3'b001 || s.f3 == 3'b101)) begin
          r.instr = {s.f7, s.imm[4:0], s.rs1, s.f3, s.rd, s.op};
          bad     = (v < 0) || (v > 31);
        end else begin
          r.instr = {s.imm[11:0], s.rs1, s.f3, s.rd, s.op};
          bad     = (v < -2048) || (v > 2047);
        end
      end
      7'b0100011: begin
        r.instr = {s.imm[11:5], s.rs2, s.rs1, s.f3, s.imm[4:0], s.op};
        bad     = (v < -2048) || (v > 2047);
      end
      7'b1100011: begin
        r.instr = {s.imm[12], s.imm[10:5], s.rs2, s.rs1, s.f3, s.imm[4:1], s.imm[11], s.op};
        bad     = (v < -4096) || (v > 4094) || (s.imm[0] != 1'b0);
      end
      7'b0110111, 7'b0010111: begin
        r.instr = {s.imm[19:0], s.rd, s.op};
        bad     = (v < -524288) || (v > 524287);
      end
      7'b1101111: begin
        r.instr = {s.imm[20], s.imm[10:1], s.imm[11], s.imm[19:12], s.rd, s.op};
        bad     = (v < -1048576) || (v > 1048574) || (s.imm[0] != 1'b0);
      end
      default: begin
        r.instr = 32'h0000_0013;
        bad     = 1'b1;
      end
    endcase
    r.err = CHK_EN & bad;
    return r;
  endfunction

  // Scoreboard: every output transfer is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got instr %h, required no output", bus.instr);
      end else begin
        e = exp_q.pop_front();
        if (bus.instr !== e.instr || bus.imm_err !== e.err ||
            bus.out_addr !== exp_addr || bus.err_count !== exp_err)
          $display("FAIL output_word: got instr %h err %b addr %0d cnt %0d, required instr %h err %b addr %0d cnt %0d",
                   bus.instr, bus.imm_err, bus.out_addr, bus.err_count, e.instr, e.err, exp_addr, exp_err);
        else
          n_pass++;
        exp_addr = exp_addr + 10'd1;
        if (e.err && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input stim_t s);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    bus.opcode = s.op; bus.rd = s.rd; bus.rs1 = s.rs1; bus.rs2 = s.rs2;
    bus.funct3 = s.f3; bus.funct7 = s.f7; bus.imm = s.imm;
    bus.in_valid = 1'b1;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      budget++;
    end
    n_checks++;
    if (!acc) $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", budget);
    else begin
      n_pass++;
      exp_q.push_back(ref_encode(s));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    do begin
      step();
      b++;
    end while (exp_q.size() != 0 && b < 50);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    step();
    step();
    reset    = 1'b0;
    exp_addr = 10'd0;
    exp_err  = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = 7'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'd0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.instr !== 32'd0 || bus.imm_err !== 1'b0)
      $display("FAIL reset_out: got valid %b instr %h err %b, required 0 0 0", bus.out_valid, bus.instr, bus.imm_err);
    else n_pass++;
    n_checks++;
    if (bus.out_addr !== 10'd0 || bus.err_count !== 8'd0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_cnt: got addr %0d cnt %0d ready %b, required 0 0 1", bus.out_addr, bus.err_count, bus.in_ready);
    else n_pass++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    send(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF));
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.instr !== 32'hFFF0_0093 || bus.imm_err !== 1'b0)
      $display("FAIL addi: got valid %b instr %h err %b, required 1 fff00093 0", bus.out_valid, bus.instr, bus.imm_err);
    else n_pass++;
    drain();
  endtask

  task automatic test_sw_jal();
    send(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8));
    @(negedge clk);
    n_checks++;
    if (bus.instr !== 32'h0020_A423 || bus.out_addr !== 10'd1)
      $display("FAIL sw: got instr %h addr %0d, required 0020a423 1", bus.instr, bus.out_addr);
    else n_pass++;
    step();
    send(mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8));
    @(negedge clk);
    n_checks++;
    if (bus.instr !== 32'h0080_00EF || bus.out_addr !== 10'd2)
      $display("FAIL jal: got instr %h addr %0d, required 008000ef 2", bus.instr, bus.out_addr);
    else n_pass++;
    drain();
  endtask

  task automatic test_errors();
    do_reset();
    bus.out_ready = 1'b1;
    send(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3));
    send(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048));
    drain();
    n_checks++;
    if (bus.err_count !== (CHK_EN ? 8'd2 : 8'd0))
      $display("FAIL err_count: got %0d, required %0d", bus.err_count, CHK_EN ? 2 : 0);
    else n_pass++;
  endtask

  task automatic test_formats();
    stim_t tbl[15];
    tbl[0]  = mk(7'b0010011, 5'd3,  5'd4,  5'd0,  3'b101, 7'b0100000, 32'd5);
    tbl[1]  = mk(7'b0010011, 5'd3,  5'd4,  5'd0,  3'b001, 7'd0,       32'd32);
    tbl[2]  = mk(7'b0000011, 5'd5,  5'd6,  5'd0,  3'b010, 7'd0,       32'hFFFF_F800);
    tbl[3]  = mk(7'b1100111, 5'd1,  5'd2,  5'd0,  3'b000, 7'd0,       32'd2047);
    tbl[4]  = mk(7'b1100011, 5'd0,  5'd1,  5'd2,  3'b001, 7'd0,       32'hFFFF_F000);
    tbl[5]  = mk(7'b1100011, 5'd0,  5'd7,  5'd8,  3'b100, 7'd0,       32'd4094);
    tbl[6]  = mk(7'b1100011, 5'd0,  5'd7,  5'd8,  3'b100, 7'd0,       32'd4096);
    tbl[7]  = mk(7'b0110111, 5'd7,  5'd0,  5'd0,  3'b000, 7'd0,       32'h0007_FFFF);
    tbl[8]  = mk(7'b0010111, 5'd9,  5'd0,  5'd0,  3'b000, 7'd0,       32'hFFF8_0000);
    tbl[9]  = mk(7'b0110111, 5'd7,  5'd0,  5'd0,  3'b000, 7'd0,       32'h0008_0000);
    tbl[10] = mk(7'b1101111, 5'd1,  5'd0,  5'd0,  3'b000, 7'd0,       32'hFFF0_0000);
    tbl[11] = mk(7'b1101111, 5'd31, 5'd0,  5'd0,  3'b000, 7'd0,       32'h000F_FFFE);
    tbl[12] = mk(7'b0110011, 5'd10, 5'd11, 5'd12, 3'b000, 7'b0100000, 32'hDEAD_BEEF);
    tbl[13] = mk(7'b1111111, 5'd1,  5'd2,  5'd3,  3'b000, 7'd0,       32'd0);
    tbl[14] = mk(7'b0100011, 5'd0,  5'd1,  5'd2,  3'b010, 7'd0,       32'hFFFF_F7FF);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(tbl[i]);
    drain();
  endtask

  task automatic test_backpressure();
    stim_t s1;
    stim_t s2;
    exp_t  e1;
    exp_t  e2;
    s1 = mk(7'b0010011, 5'd2, 5'd3, 5'd0, 3'b000, 7'd0, 32'd100);
    s2 = mk(7'b0110011, 5'd4, 5'd5, 5'd6, 3'b111, 7'd0, 32'd0);
    e1 = ref_encode(s1);
    e2 = ref_encode(s2);
    bus.out_ready = 1'b0;
    send(s1);
    fork
      send(s2);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n_checks++;
          if (bus.out_valid !== 1'b1 || bus.instr !== e1.instr || bus.in_ready !== 1'b0)
            $display("FAIL hold_%0d: got valid %b instr %h ready %b, required 1 %h 0",
                     c, bus.out_valid, bus.instr, bus.in_ready, e1.instr);
          else n_pass++;
        end
        step();
        bus.out_ready = 1'b1;
      end
    join
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.instr !== e2.instr)
      $display("FAIL second_word: got valid %b instr %h, required 1 %h", bus.out_valid, bus.instr, e2.instr);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 255; i++) send(mk(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd4096));
    drain();
    n_checks++;
    if (bus.err_count !== (CHK_EN ? 8'd255 : 8'd0))
      $display("FAIL err_255: got %0d, required %0d", bus.err_count, CHK_EN ? 255 : 0);
    else n_pass++;
    send(mk(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd4096));
    drain();
    n_checks++;
    if (bus.err_count !== (CHK_EN ? 8'd255 : 8'd0))
      $display("FAIL err_sat: got %0d, required %0d", bus.err_count, CHK_EN ? 255 : 0);
    else n_pass++;
    for (int i = 0; i < 769; i++) send(mk(7'b0010011, 5'd2, 5'd2, 5'd0, 3'b000, 7'd0, 32'd1));
    drain();
    n_checks++;
    if (bus.out_addr !== 10'd1)
      $display("FAIL addr_wrap: got %0d, required 1", bus.out_addr);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7));
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL pending_word: got valid %b ready %b, required 1 0", bus.out_valid, bus.in_ready);
    else n_pass++;
    step();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 10'd0 || bus.err_count !== 8'd0 || bus.in_ready !== 1'b1)
      $display("FAIL mid_reset: got valid %b addr %0d cnt %0d ready %b, required 0 0 0 1",
               bus.out_valid, bus.out_addr, bus.err_count, bus.in_ready);
    else n_pass++;
    step();
    reset         = 1'b0;
    exp_addr      = 10'd0;
    exp_err       = 8'd0;
    bus.out_ready = 1'b1;
    send(mk(7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0001_2345));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_sw_jal();
    test_errors();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_instr_encoder.md
RISCV_INSTR_ENCODER -- requirements
Module: riscv_instr_encoder

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports in_valid in 1 and in_ready out 1, the input handshake; a transfer occurs when both are 1 on a rising edge.
REQ-004 SHALL have input fields opcode in 7, rd in 5, rs1 in 5, rs2 in 5, funct3 in 3, funct7 in 7, and imm in 32, where imm is the full sign-extended immediate value.
REQ-005 SHALL have ports out_valid out 1 and out_ready in 1, the output handshake.
REQ-006 SHALL have port instr out 32, the encoded instruction word.
REQ-007 SHALL have port imm_err out 1, the error flag qualified by out_valid.
REQ-008 SHALL have port out_addr out 10, the word index of the current output.
REQ-009 SHALL have port err_count out 8, a saturating count of error transfers.

Function
REQ-010 SHALL register the encoding of each accepted input, giving a 1-cycle latency: out_valid is 1 on the edge after acceptance.
REQ-011 SHALL drive in_ready = !out_valid || out_ready, which gives full throughput and one word of buffering.
REQ-012 SHALL hold instr, imm_err and out_addr stable while out_valid=1 and out_ready=0.
REQ-013 SHALL clear out_valid after an output transfer only if no new input is accepted on the same edge.
REQ-014 SHALL encode the immediate for opcodes 0010011, 0000011 and 1100111 (I-type) as imm[11:0] in [31:20], with range -2048..2047.
REQ-015 SHALL encode I-type shifts (opcode 0010011, funct3 001 or 101) as funct7 in [31:25] and imm[4:0] in [24:20], with range 0..31.
REQ-016 SHALL encode the immediate for S-type (0100011) as imm[11:5] in [31:25] and imm[4:0] in [11:7], with range -2048..2047.
REQ-017 SHALL encode the immediate for B-type (1100011) as imm[12|10:5] in [31:25] and imm[4:1|11] in [11:7], with range -4096..4094 and imm[0]=0 required.
REQ-018 SHALL encode the immediate for U-type (0110111, 0010111) as imm[19:0] in [31:12], with range -524288..524287.
REQ-019 SHALL encode the immediate for JAL (1101111) as imm[20|10:1|11|19:12] in [31:12], with range -1048576..1048574 and imm[0]=0 required.
REQ-020 SHALL encode R-type (0110011) as funct7/rs2/rs1/funct3/rd, ignoring imm; imm_err=0.
REQ-021 SHALL place the rd, rs1, rs2 and funct3 fields at their standard positions for every format that carries them.
REQ-022 SHALL, for an unsupported opcode, output instr=32'h00000013 (NOP) with imm_err=1.
REQ-023 SHALL set imm_err=1 for a value out of range or misaligned, and SHALL still output the truncated field bits in that case.
REQ-024 SHALL increment out_addr by 1 on each output transfer, wrapping from 1023 to 0.
REQ-025 SHALL increment err_count on each output transfer with imm_err=1, saturating at 255.

Reset
REQ-026 SHALL, on reset, set out_valid=0, instr=0, imm_err=0, out_addr=0 and err_count=0; in_ready=1 in the following cycle.
REQ-027 SHALL give reset priority over any simultaneous transfer, discarding a pending output word.

Configuration
REQ-028 SHALL, with RISCV_IMM_RANGE_CHECK_EN defined, perform the range and alignment checks of REQ-014..REQ-023.
REQ-029 SHALL, without RISCV_IMM_RANGE_CHECK_EN, tie imm_err and err_count to 0 and silently truncate fields; an unsupported opcode still gives NOP.

Structure
REQ-030 SHALL take the opcode constants (R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, AUIPC, LUI, JAL, JALR) and the NOP constant from the shared package riscv_pkg.
REQ-031 SHALL implement the combinational field packing and range checking in the sub-module riscv_imm_pack; riscv_instr_encoder holds only the handshake, the registers and the counters.

Verification
REQ-032 SHALL cover: ADDI (opcode 0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF) -> instr=32'hFFF00093, imm_err=0.
REQ-033 SHALL cover: SW (rs1=1, rs2=2, funct3=010, imm=8) -> instr=32'h0020A423; then JAL (rd=1, imm=8) -> instr=32'h008000EF, out_addr increments by 1 per transfer.
REQ-034 SHALL cover: BEQ with imm=3, then ADDI with imm=2048 -> imm_err=1 on both, err_count=2.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with two inputs offered -> first word held stable, in_ready=0, second word accepted on the cycle out_ready rises, no loss or duplication.
REQ-036 SHALL cover: 256 back-to-back error transfers -> err_count stays at 255; 1025 transfers -> out_addr=1.
REQ-037 SHALL cover: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=0, err_count=0, in_ready=1.
